// File: rtl/elevador_ctrl_param.sv
// ---------------------------------------------------------------------------
// elevador_ctrl_param
//
// Parametrised elevator controller. Floor requests are latched into a pending
// mask and served with a direction-preserving sweep (SCAN): the car keeps
// moving in its current direction while requests remain ahead of it, then
// reverses. Floor travel and door dwell are timed in clock cycles. A
// saturating occupancy counter tracks people entering/leaving while the door
// is open.
//
// Ports:
//   clk                - system clock, all logic on the rising edge
//   reset              - synchronous, active-low
//   req                - level floor requests, bit i = floor i
//   person_enter       - rising edge = one person enters (counted in DOOR)
//   person_exit        - rising edge = one person leaves (counted in DOOR)
//   door_hold          - while high in DOOR the dwell timer restarts
//   motor_up           - car travelling up
//   motor_down         - car travelling down
//   door_open          - door open (DOOR state)
//   andar_atual        - current floor
//   andar_requisitado  - current target floor (one cycle latency)
//   num_people         - occupancy
//   overload           - occupancy at MAX_PEOPLE
//   pending            - latched request mask
// ---------------------------------------------------------------------------
module elevador_ctrl_param #(
    parameter int N_FLOORS    = 5,
    parameter int FLOOR_W     = $clog2(N_FLOORS),
    parameter int MOVE_CYCLES = 50000000,
    parameter int DOOR_CYCLES = 100000000,
    parameter int MAX_PEOPLE  = 9,
    parameter int PEOPLE_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] req,
    input  logic                person_enter,
    input  logic                person_exit,
    input  logic                door_hold,
    output logic                motor_up,
    output logic                motor_down,
    output logic                door_open,
    output logic [FLOOR_W-1:0]  andar_atual,
    output logic [FLOOR_W-1:0]  andar_requisitado,
    output logic [PEOPLE_W-1:0] num_people,
    output logic                overload,
    output logic [N_FLOORS-1:0] pending
);

    localparam int MOVE_W = $clog2(MOVE_CYCLES);
    localparam int DOOR_W = $clog2(DOOR_CYCLES);

    localparam logic [MOVE_W-1:0]   MOVE_LAST = MOVE_W'(MOVE_CYCLES - 1);
    localparam logic [DOOR_W-1:0]   DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0]  TOP_FLOOR = FLOOR_W'(N_FLOORS - 1);
    localparam logic [PEOPLE_W-1:0] MAX_P     = PEOPLE_W'(MAX_PEOPLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    // One-hot mask of floor f.
    function automatic logic [N_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
        logic [N_FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (FLOOR_W'(i) == f) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Mask of floors strictly above f.
    function automatic logic [N_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
        logic [N_FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            m[i] = (FLOOR_W'(i) > f);
        end
        return m;
    endfunction

    // Mask of floors strictly below f.
    function automatic logic [N_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
        logic [N_FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            m[i] = (FLOOR_W'(i) < f);
        end
        return m;
    endfunction

    // Nearest pending floor in direction d, else nearest in the opposite
    // direction, else the current floor.
    function automatic logic [FLOOR_W-1:0] pick_target(input logic [N_FLOORS-1:0] p,
                                                       input logic [FLOOR_W-1:0]  f,
                                                       input dir_t                d);
        logic [N_FLOORS-1:0] up_set;
        logic [N_FLOORS-1:0] dn_set;
        logic [FLOOR_W-1:0]  up_f;
        logic [FLOOR_W-1:0]  dn_f;
        logic [FLOOR_W-1:0]  t;
        up_set = p & above_mask(f);
        dn_set = p & below_mask(f);
        up_f   = f;
        dn_f   = f;
        // Descending scan leaves the lowest floor above f.
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (up_set[i]) up_f = FLOOR_W'(i);
        end
        // Ascending scan leaves the highest floor below f.
        for (int i = 0; i < N_FLOORS; i++) begin
            if (dn_set[i]) dn_f = FLOOR_W'(i);
        end
        if (d == UP) begin
            t = (|up_set) ? up_f : ((|dn_set) ? dn_f : f);
        end else begin
            t = (|dn_set) ? dn_f : ((|up_set) ? up_f : f);
        end
        return t;
    endfunction

    state_t              state;
    dir_t                dir;
    logic [MOVE_W-1:0]   move_cnt;
    logic [DOOR_W-1:0]   door_cnt;
    logic                enter_q;
    logic                exit_q;

    logic [N_FLOORS-1:0] here_bit;
    logic [N_FLOORS-1:0] above_here;
    logic [N_FLOORS-1:0] below_here;
    logic [N_FLOORS-1:0] pending_lat;
    logic                req_here;
    logic                go_up;
    logic [FLOOR_W-1:0]  next_floor;
    logic [N_FLOORS-1:0] next_bit;
    logic [N_FLOORS-1:0] beyond_next;
    logic                enter_edge;
    logic                exit_edge;

    assign here_bit   = floor_bit(andar_atual);
    assign above_here = above_mask(andar_atual);
    assign below_here = below_mask(andar_atual);
    assign req_here   = |(req & here_bit);

    // A request for the floor the car is standing at (IDLE or DOOR) is served
    // by the door directly and never enters the pending mask.
    assign pending_lat = pending |
                         (req & ~(((state == IDLE) || (state == DOOR)) ? here_bit : '0));

    // SCAN decision: keep going up if there is work above and either we were
    // already going up or nothing waits below.
    assign go_up = (|(pending & above_here)) &&
                   ((dir == UP) || !(|(pending & below_here)));

    // Floor reached at the end of the current travel leg, clamped to the shaft.
    always_comb begin
        next_floor = andar_atual;
        if ((dir == UP) && (andar_atual != TOP_FLOOR)) begin
            next_floor = andar_atual + FLOOR_W'(1);
        end else if ((dir == DOWN) && (andar_atual != '0)) begin
            next_floor = andar_atual - FLOOR_W'(1);
        end
    end

    assign next_bit    = floor_bit(next_floor);
    assign beyond_next = pending & ((dir == UP) ? above_mask(next_floor)
                                                : below_mask(next_floor));

    assign enter_edge = person_enter & ~enter_q;
    assign exit_edge  = person_exit & ~exit_q;
    assign overload   = (num_people == MAX_P);

    // Main controller FSM with registered motor/door outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state             <= IDLE;
            dir               <= UP;
            andar_atual       <= '0;
            andar_requisitado <= '0;
            pending           <= '0;
            move_cnt          <= '0;
            door_cnt          <= '0;
            motor_up          <= 1'b0;
            motor_down        <= 1'b0;
            door_open         <= 1'b0;
        end else begin
            pending           <= pending_lat;
            andar_requisitado <= pick_target(pending, andar_atual, dir);

            unique case (state)
                IDLE: begin
                    // The pending check on the current floor only matters if a
                    // request for it was latched on the very edge the car
                    // arrived without stopping; the door then serves it here.
                    if (req_here || (|(pending & here_bit))) begin
                        state     <= DOOR;
                        door_cnt  <= '0;
                        door_open <= 1'b1;
                        pending   <= pending_lat & ~here_bit;
                    end else if (|pending) begin
                        state    <= MOVE;
                        move_cnt <= '0;
                        if (go_up) begin
                            dir        <= UP;
                            motor_up   <= 1'b1;
                            motor_down <= 1'b0;
                        end else begin
                            dir        <= DOWN;
                            motor_up   <= 1'b0;
                            motor_down <= 1'b1;
                        end
                    end
                end

                MOVE: begin
                    if (move_cnt == MOVE_LAST) begin
                        move_cnt    <= '0;
                        andar_atual <= next_floor;
                        if (|(pending & next_bit)) begin
                            state      <= DOOR;
                            door_cnt   <= '0;
                            door_open  <= 1'b1;
                            motor_up   <= 1'b0;
                            motor_down <= 1'b0;
                            pending    <= pending_lat & ~next_bit;
                        end else if (!(|beyond_next)) begin
                            state      <= IDLE;
                            motor_up   <= 1'b0;
                            motor_down <= 1'b0;
                        end
                    end else begin
                        move_cnt <= move_cnt + MOVE_W'(1);
                    end
                end

                DOOR: begin
                    if (door_hold || req_here) begin
                        door_cnt <= '0;
                    end else if (door_cnt == DOOR_LAST) begin
                        state     <= IDLE;
                        door_cnt  <= '0;
                        door_open <= 1'b0;
                    end else begin
                        door_cnt <= door_cnt + DOOR_W'(1);
                    end
                end

                default: begin
                    state      <= IDLE;
                    motor_up   <= 1'b0;
                    motor_down <= 1'b0;
                    door_open  <= 1'b0;
                end
            endcase
        end
    end

    // Occupancy: edges only count while the door is open; simultaneous
    // enter/exit edges cancel out.
    always_ff @(posedge clk) begin
        if (!reset) begin
            enter_q    <= 1'b0;
            exit_q     <= 1'b0;
            num_people <= '0;
        end else begin
            enter_q <= person_enter;
            exit_q  <= person_exit;
            if ((state == DOOR) && (enter_edge ^ exit_edge)) begin
                if (enter_edge) begin
                    if (num_people < MAX_P) num_people <= num_people + PEOPLE_W'(1);
                end else begin
                    if (num_people != '0) num_people <= num_people - PEOPLE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_elevador_ctrl_param.sv
// ---------------------------------------------------------------------------
// tb_elevador_ctrl_param
//
// Scoreboard bench for elevador_ctrl_param (5 floors, 4-cycle travel,
// 6-cycle dwell, 9 people). The stimulus process drives one cycle of inputs,
// advances a behavioural model of the elevator and queues the outputs the
// DUT must show after the next clock edge; a monitor process pops and
// compares after every edge.
// ---------------------------------------------------------------------------
module tb_elevador_ctrl_param;

    localparam int NF    = 5;
    localparam int MOVEC = 4;
    localparam int DOORC = 6;
    localparam int MAXP  = 9;

    localparam int PH_IDLE = 0;
    localparam int PH_MOVE = 1;
    localparam int PH_DOOR = 2;

    typedef struct packed {
        logic       mu;
        logic       md;
        logic       dopen;
        logic [2:0] fl;
        logic [2:0] tgt;
        logic [3:0] np;
        logic       ov;
        logic [4:0] pend;
    } obs_t;

    logic       clk;
    logic       reset;
    logic [4:0] req;
    logic       person_enter;
    logic       person_exit;
    logic       door_hold;
    logic       motor_up;
    logic       motor_down;
    logic       door_open;
    logic [2:0] andar_atual;
    logic [2:0] andar_requisitado;
    logic [3:0] num_people;
    logic       overload;
    logic [4:0] pending;

    int n_tests;
    int n_fail;
    int cyc;

    obs_t exp_q[$];
    int   cyc_q[$];

    // Behavioural model state
    int       m_phase;
    bit       m_up;
    int       m_floor;
    bit [4:0] m_pend;
    int       m_left;
    int       m_people;
    bit       m_pen;
    bit       m_pex;
    int       m_tgt;

    elevador_ctrl_param #(
        .N_FLOORS   (NF),
        .MOVE_CYCLES(MOVEC),
        .DOOR_CYCLES(DOORC),
        .MAX_PEOPLE (MAXP),
        .PEOPLE_W   (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .person_enter     (person_enter),
        .person_exit      (person_exit),
        .door_hold        (door_hold),
        .motor_up         (motor_up),
        .motor_down       (motor_down),
        .door_open        (door_open),
        .andar_atual      (andar_atual),
        .andar_requisitado(andar_requisitado),
        .num_people       (num_people),
        .overload         (overload),
        .pending          (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Nearest pending floor from f going up (up=1) or down; -1 if none.
    function automatic int nearest(input bit [4:0] p, input int f, input bit up);
        for (int d = 1; d < NF; d++) begin
            int c;
            c = up ? f + d : f - d;
            if (c >= 0 && c < NF) begin
                if (p[c]) return c;
            end
        end
        return -1;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.mu    = (m_phase == PH_MOVE) && m_up;
        o.md    = (m_phase == PH_MOVE) && !m_up;
        o.dopen = (m_phase == PH_DOOR);
        o.fl    = 3'(m_floor);
        o.tgt   = 3'(m_tgt);
        o.np    = 4'(m_people);
        o.ov    = (m_people == MAXP);
        o.pend  = m_pend;
        return o;
    endfunction

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(input logic [4:0] r, input logic en, input logic ex,
                              input logic hold, input logic rst);
        bit [4:0] newp;
        int       here;
        int       t;
        bit       en_edge;
        bit       ex_edge;
        if (!rst) begin
            m_phase  = PH_IDLE;
            m_up     = 1'b1;
            m_floor  = 0;
            m_pend   = '0;
            m_left   = 0;
            m_people = 0;
            m_pen    = 1'b0;
            m_pex    = 1'b0;
            m_tgt    = 0;
            return;
        end
        here = m_floor;

        // Target shown after this edge comes from the state before it.
        t = nearest(m_pend, here, m_up);
        if (t < 0) t = nearest(m_pend, here, !m_up);
        if (t < 0) t = here;
        m_tgt = t;

        en_edge = en && !m_pen;
        ex_edge = ex && !m_pex;
        m_pen   = en;
        m_pex   = ex;
        if (m_phase == PH_DOOR && en_edge != ex_edge) begin
            if (en_edge && m_people < MAXP) m_people++;
            if (ex_edge && m_people > 0) m_people--;
        end

        newp = m_pend;
        for (int i = 0; i < NF; i++) begin
            if (r[i] && !(i == here && m_phase != PH_MOVE)) newp[i] = 1'b1;
        end

        case (m_phase)
            PH_IDLE: begin
                if (r[here] || m_pend[here]) begin
                    m_phase    = PH_DOOR;
                    m_left     = DOORC;
                    newp[here] = 1'b0;
                end else if (m_pend != 0) begin
                    m_up    = (nearest(m_pend, here, 1'b1) >= 0) &&
                              (m_up || nearest(m_pend, here, 1'b0) < 0);
                    m_phase = PH_MOVE;
                    m_left  = MOVEC;
                end
            end
            PH_MOVE: begin
                if (m_left == 1) begin
                    m_floor = m_up ? here + 1 : here - 1;
                    if (m_pend[m_floor]) begin
                        m_phase       = PH_DOOR;
                        m_left        = DOORC;
                        newp[m_floor] = 1'b0;
                    end else if (nearest(m_pend, m_floor, m_up) < 0) begin
                        m_phase = PH_IDLE;
                    end else begin
                        m_left = MOVEC;
                    end
                end else begin
                    m_left--;
                end
            end
            default: begin
                if (hold || r[here]) begin
                    m_left = DOORC;
                end else if (m_left == 1) begin
                    m_phase = PH_IDLE;
                end else begin
                    m_left--;
                end
            end
        endcase
        m_pend = newp;
    endtask

    // One clock cycle of stimulus plus the matching expectation.
    task automatic step(input logic [4:0] r, input logic en, input logic ex,
                        input logic hold, input logic rst);
        @(negedge clk);
        #1;
        req          = r;
        person_enter = en;
        person_exit  = ex;
        door_hold    = hold;
        reset        = rst;
        model_step(r, en, ex, hold, rst);
        cyc++;
        exp_q.push_back(model_obs());
        cyc_q.push_back(cyc);
    endtask

    task automatic idle_steps(input int n, input logic hold);
        for (int i = 0; i < n; i++) step(5'b0, 1'b0, 1'b0, hold, 1'b1);
    endtask

    task automatic check_val(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Monitor: compare DUT outputs after each edge with the queued expectation.
    initial begin
        obs_t a;
        obs_t e;
        int   c;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                a = {motor_up, motor_down, door_open, andar_atual, andar_requisitado,
                     num_people, overload, pending};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cyc%0d outputs: got up=%0b dn=%0b door=%0b fl=%0d tgt=%0d np=%0d ov=%0b pend=%b, expected up=%0b dn=%0b door=%0b fl=%0d tgt=%0d np=%0d ov=%0b pend=%b",
                             c, a.mu, a.md, a.dopen, a.fl, a.tgt, a.np, a.ov, a.pend,
                             e.mu, e.md, e.dopen, e.fl, e.tgt, e.np, e.ov, e.pend);
                end
            end
        end
    end

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        cyc          = 0;
        reset        = 1'b0;
        req          = '0;
        person_enter = 1'b0;
        person_exit  = 1'b0;
        door_hold    = 1'b0;

        // Reset with all inputs low.
        for (int i = 0; i < 3; i++) step(5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_steps(2, 1'b0);
        check_val("reset_floor", int'(andar_atual), 0);
        check_val("reset_pending", int'(pending), 0);

        // Single request for floor 2 from floor 0.
        step(5'b00100, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_steps(25, 1'b0);
        check_val("served_floor2", int'(andar_atual), 2);

        // From floor 2 heading up with floors 0 and 4 pending.
        step(5'b10001, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_steps(60, 1'b0);

        // Door at floor 0: same-floor request during dwell and a hold pulse.
        step(5'b00001, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_steps(2, 1'b0);
        step(5'b00001, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_steps(3, 1'b0);
        step(5'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_steps(12, 1'b0);

        // Ten entries while the door is held: saturates at the limit.
        step(5'b00001, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(5'b0, 1'b1, 1'b0, 1'b1, 1'b1);
            step(5'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        idle_steps(2, 1'b1);
        check_val("people_sat", int'(num_people), 9);
        check_val("overload_set", int'(overload), 1);
        step(5'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle_steps(2, 1'b1);
        check_val("people_exit", int'(num_people), 8);
        check_val("overload_clr", int'(overload), 0);
        idle_steps(10, 1'b0);
        step(5'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle_steps(2, 1'b0);
        check_val("enter_idle_ignored", int'(num_people), 8);

        // Simultaneous edges at 3, then exits down past zero.
        step(5'b00001, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(5'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            step(5'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        step(5'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        idle_steps(2, 1'b1);
        check_val("people_simul", int'(num_people), 3);
        for (int i = 0; i < 4; i++) begin
            step(5'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            step(5'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        idle_steps(1, 1'b1);
        check_val("people_floor0", int'(num_people), 0);
        idle_steps(10, 1'b0);

        // Reset while moving between floors.
        step(5'b10000, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_steps(6, 1'b0);
        check_val("moving_before_reset", int'(motor_up), 1);
        step(5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_steps(1, 1'b0);
        check_val("reset_move_floor", int'(andar_atual), 0);
        check_val("reset_move_motor", int'(motor_up), 0);

        // Randomised traffic, occasional holds and resets.
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] r;
            logic       en;
            logic       ex;
            logic       hold;
            logic       rst;
            r    = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'b0;
            en   = ($urandom_range(0, 3) == 0);
            ex   = ($urandom_range(0, 3) == 0);
            hold = ($urandom_range(0, 7) == 0);
            rst  = ($urandom_range(0, 599) != 0);
            step(r, en, ex, hold, rst);
        end
        idle_steps(2, 1'b0);

        // Drain the scoreboard, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        #4;
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/elevador_ctrl_param.md
Name: elevador_ctrl_param

Overview:
Parametrised elevator controller, next generation of the fixed 5-floor `elevador` core. Latches floor requests into a pending mask and serves them with a direction-preserving sweep (SCAN). Drives motor and door outputs with timed floor travel and timed door dwell, and keeps a saturating occupancy count with overload flag. Instantiated by the board top in place of the old core; outputs feed LEDs and the 7-seg decoder unchanged.

Parameters:
N_FLOORS, 5, number of floors (2..16); floors numbered 0..N_FLOORS-1
FLOOR_W, $clog2(N_FLOORS), width of floor outputs
MOVE_CYCLES, 50000000, clk cycles to travel one floor (>=2)
DOOR_CYCLES, 100000000, clk cycles door stays open (>=2)
MAX_PEOPLE, 9, occupancy limit
PEOPLE_W, 4, width of num_people (must hold MAX_PEOPLE)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low: reset=0 at a rising clk edge resets all state
req  input  N_FLOORS  level floor requests, bit i = floor i
person_enter  input  1  rising edge = one person enters
person_exit  input  1  rising edge = one person leaves
door_hold  input  1  while 1 in DOOR, dwell timer restarts
motor_up  output  1  state==MOVE and dir==UP
motor_down  output  1  state==MOVE and dir==DOWN
door_open  output  1  state==DOOR
andar_atual  output  FLOOR_W  current floor
andar_requisitado  output  FLOOR_W  current target floor
num_people  output  PEOPLE_W  occupancy
overload  output  1  num_people==MAX_PEOPLE
pending  output  N_FLOORS  latched request mask

Behaviour:
- Reset: state=IDLE, dir=UP, andar_atual=0, andar_requisitado=0, pending=0, num_people=0, timers=0, edge-detect regs=0; all outputs 0. Reset mid-MOVE or mid-DOOR aborts immediately; reset has priority over every event.
- Request latch: each cycle pending[i] <= pending[i] | req[i], except req[i] for i==andar_atual while state is IDLE or DOOR: not latched; in DOOR it restarts the dwell timer; in IDLE it enters DOOR next cycle.
- IDLE: if pending==0 stay. Else, if pending has a bit above andar_atual and (dir==UP or no bit below): dir<=UP, go MOVE. Else dir<=DOWN, go MOVE. Decision takes one cycle.
- MOVE: move_cnt counts 0..MOVE_CYCLES-1. At MOVE_CYCLES-1, andar_atual +/-1 per dir and move_cnt<=0. Then at the new floor F:
  - if pending[F]: clear it, go DOOR;
  - else if pending bits remain beyond F in dir: stay MOVE;
  - else go IDLE.
  Never moves below 0 or above N_FLOORS-1.
- DOOR: door_cnt counts 0..DOOR_CYCLES-1, then go IDLE. door_hold=1 or a same-floor req forces door_cnt<=0. door_open is high exactly DOOR_CYCLES cycles when there is no hold.
- Occupancy: rising edges are detected with one register stage per input and are counted only in DOOR; edges outside DOOR are discarded.
  - enter edge with num_people<MAX_PEOPLE: +1; at MAX_PEOPLE it is ignored.
  - exit edge with num_people>0: -1; at 0 it is ignored.
  - simultaneous enter and exit edges: no change.
  - An input held high through reset produces an edge on the first cycle after reset.
- andar_requisitado: registered, updated every cycle (1-cycle latency) to:
  - nearest pending floor in direction dir;
  - else nearest pending floor in the other direction;
  - else andar_atual.

Test Plan:
- Reset with MOVE_CYCLES=4, DOOR_CYCLES=6, N_FLOORS=5, all inputs 0 -> every output 0, andar_atual=0, pending=0.
- 1-cycle pulse req=5'b00100 at floor 0 -> pending=00100, motor_up=1 two cycles later; andar_atual=1 after 4 MOVE cycles and =2 after 8; then motor_up=0, door_open=1 for exactly 6 cycles, pending=0, state IDLE.
- At floor 2 moving up, pending floors 0 and 4 -> serves 4 first, then reverses to 0; andar_requisitado=4 then 0.
- req for current floor while door_open, plus door_hold pulse at dwell cycle 4 -> door_cnt restarts, door_open lasts 4+6 cycles, pending unchanged.
- 10 enter pulses in DOOR with MAX_PEOPLE=9 -> num_people=9, overload=1. Then 1 exit -> num_people=8, overload=0. Enter pulse in IDLE -> no change.
- Simultaneous enter and exit edges at num_people=3 -> stays 3. Exit at 0 -> stays 0. reset=0 during MOVE -> next cycle andar_atual=0, motor outputs 0.
